rom16_reader: RTL and testbench
===============================

# rom16_reader

Sequential read-out controller that sits directly upstream and downstream of a ROM16 LUT primitive: it drives the ROM16 4-bit address input and collects the 1-bit data output. On a start request it sweeps a programmable run of consecutive addresses, wrapping modulo 16. It assembles the bits into a right-justified word and presents it with a one-cycle valid strobe. It is used in Verilator simulation benches to dump or check LUT contents, and as a bit-serial table reader in Gowin designs.

## Interface
- LSB_FIRST, 1: 1 = bit read from the first address lands in DATA[0]; 0 = first bit lands in DATA[LEN-1].
- CLK  input  1  clock; all state changes on the rising edge.
- RESET  input  1  synchronous, active-high reset.
- START  input  1  request; sampled only while BUSY=0.
- ADDR  input  4  first ROM16 address of the run; sampled with START.
- LEN  input  5  number of bits to read, 1..16; sampled with START.
- BUSY  output  1  high while a run is in progress.
- AD  output  4  registered address to ROM16 AD.
- DI  input  1  ROM16 DO. Combinational with respect to AD.
- DATA  output  16  result word; holds its value until the next run completes.
- VALID  output  1  one-cycle strobe marking a new DATA value.

## Operation
- Reset values: AD=0, DATA=0, VALID=0, BUSY=0, state IDLE. An internal shift register and counter also clear.
- States: IDLE, READ, and FLUSH (FLUSH exists only with the macro below).
- IDLE, START=1, LEN in 1..16:
  - AD<=ADDR, counter<=LEN, shift register<=0, BUSY<=1, go to READ.
- IDLE, START=1, LEN=0: request ignored. No BUSY, no VALID.
- IDLE, START=1, LEN>16: treated as LEN=16.
- READ, each edge:
  - Sample DI into the shift register.
  - LSB_FIRST=1: shift right and insert at bit LEN-1.
  - LSB_FIRST=0: shift left and insert at bit 0.
  - AD<=AD+1 modulo 16 (15 wraps to 0). counter<=counter-1.
- READ, final sample (counter=1):
  - DATA<=assembled word, bits [15:LEN] forced to 0.
  - VALID<=1, BUSY<=0, return to IDLE.
- START while BUSY=1: ignored. It is not queued.
- VALID is high for exactly one cycle per completed run. DATA does not change during a run.
- RESET asserted mid-run: run aborts, no VALID, all outputs return to their reset values on that edge.
- AD keeps its last value in IDLE. It is not returned to 0 except by reset.

## Timing
- Call the edge that samples START "edge 0". AD=ADDR is visible after edge 0.
- The bit for run position k (k=0..LEN-1) is sampled at edge k+1.
- VALID and DATA update at edge LEN. BUSY falls at the same edge.
- Throughput: a new START is accepted in the cycle VALID is high. The minimum period between runs is LEN+1 cycles.

## Configuration
- ROM16_RDR_REGIN_EN defined:
  - DI is registered once before sampling, for use when a pipeline register follows the ROM16.
  - After the last address is issued, the FSM enters FLUSH for one cycle to capture the final bit.
  - All sample edges and VALID/DATA/BUSY-fall move one edge later: VALID at edge LEN+1.
  - The input register clears on RESET.
- Macro not defined: DI is sampled directly, no FLUSH state, latency exactly as stated under Timing.

## Test plan
All scenarios use a ROM16 model with INIT_0=16'hA5C3.
- Full sweep: LSB_FIRST=1, ADDR=0, LEN=16. Expect DATA=16'hA5C3, VALID for one cycle at edge 16, BUSY high for edges 0..15.
- Wrap-around: LSB_FIRST=1, ADDR=14, LEN=4. Expect AD sequence 14,15,0,1 and DATA=16'h000E at edge 4.
- Bit order: LSB_FIRST=0, ADDR=0, LEN=4. Expect DATA=16'h000C. Upper 12 bits are 0.
- Ignored requests:
  - LEN=0: no BUSY, no VALID.
  - START pulsed again at edge 2 of a LEN=8 run: exactly one VALID, at edge 8, and no second run.
- Reset mid-run: RESET at edge 3 of a LEN=16 run. Expect no VALID afterwards, DATA=0, AD=0, BUSY=0 after that edge. A subsequent run then completes normally.
- With ROM16_RDR_REGIN_EN: repeat the full sweep. Expect DATA=16'hA5C3 with VALID at edge 17.

Source files
------------

// File: rtl/rom16_reader_if.sv
// rom16_reader_if: request/result bus and ROM16 address/data pins of the reader
interface rom16_reader_if;
  logic        start;
  logic [3:0]  addr;
  logic [4:0]  len;
  logic        busy;
  logic [3:0]  ad;
  logic        di;
  logic [15:0] data;
  logic        valid;
  modport master (output start, addr, len, di, input busy, ad, data, valid);
  modport slave  (input start, addr, len, di, output busy, ad, data, valid);
endinterface

// File: rtl/rom16_reader.sv
// rom16_reader: sweeps consecutive ROM16 addresses and assembles the bits into a word
// Optional ROM16_RDR_REGIN_EN registers DI and adds a FLUSH cycle for the last bit.
module rom16_reader #(
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic           i_clk,
  input  logic           i_rst,
  rom16_reader_if.slave  bus
);
`ifdef ROM16_RDR_REGIN_EN
  typedef enum logic [1:0] {IDLE, READ, FLUSH} state_t;
`else
  typedef enum logic {IDLE, READ} state_t;
`endif
  state_t      r_state, w_state;
  logic [3:0]  r_ad, w_ad;
  logic [4:0]  r_cnt, w_cnt, r_len, w_len, w_req;
  logic [15:0] r_sr, w_sr, r_data, w_data, w_ins, w_mask;
  logic        r_valid, w_valid, r_busy, w_busy;
  logic        w_bit, w_smp, w_done;
  assign w_req  = bus.len > 5'd16 ? 5'd16 : bus.len;
  assign w_mask = 16'((32'd1 << r_len) - 32'd1);
  assign w_ins  = LSB_FIRST ? ((r_sr >> 1) | (16'(w_bit) << (r_len - 5'd1)))
                            : {r_sr[14:0], w_bit};
`ifdef ROM16_RDR_REGIN_EN
  logic r_di;
  always_ff @(posedge i_clk) r_di <= i_rst ? 1'b0 : bus.di;
  // first READ cycle sees stale r_di, so sampling lags address issue by one edge
  assign w_bit  = r_di;
  assign w_smp  = (r_state == READ && r_cnt != r_len) || r_state == FLUSH;
  assign w_done = r_state == FLUSH;
`else
  assign w_bit  = bus.di;
  assign w_smp  = r_state == READ;
  assign w_done = r_state == READ && r_cnt == 5'd1;
`endif
  always_comb begin
    w_state = r_state;
    w_ad    = r_ad;
    w_cnt   = r_cnt;
    w_len   = r_len;
    w_sr    = w_smp ? w_ins : r_sr;
    w_data  = r_data;
    w_valid = 1'b0;
    w_busy  = r_busy;
    if (r_state == IDLE && bus.start && w_req != 5'd0) begin
      w_state = READ;
      w_ad    = bus.addr;
      w_cnt   = w_req;
      w_len   = w_req;
      w_sr    = '0;
      w_busy  = 1'b1;
    end
    if (r_state == READ) begin
      w_ad  = r_ad + 4'd1;
      w_cnt = r_cnt - 5'd1;
    end
`ifdef ROM16_RDR_REGIN_EN
    if (r_state == READ && r_cnt == 5'd1) w_state = FLUSH;
`endif
    if (w_done) begin
      w_data  = w_ins & w_mask;
      w_valid = 1'b1;
      w_busy  = 1'b0;
      w_state = IDLE;
    end
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= IDLE;
      r_ad    <= '0;
      r_cnt   <= '0;
      r_len   <= '0;
      r_sr    <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state;
      r_ad    <= w_ad;
      r_cnt   <= w_cnt;
      r_len   <= w_len;
      r_sr    <= w_sr;
      r_data  <= w_data;
      r_valid <= w_valid;
      r_busy  <= w_busy;
    end
  end
  assign bus.ad    = r_ad;
  assign bus.data  = r_data;
  assign bus.valid = r_valid;
  assign bus.busy  = r_busy;
endmodule

// File: tb/tb_rom16_reader.sv
// tb_rom16_reader: directed and random runs on LSB-first and MSB-first readers against a ROM model
module tb_rom16_reader;
`ifdef ROM16_RDR_REGIN_EN
  localparam int REGIN = 1;
`else
  localparam int REGIN = 0;
`endif
  logic        clk = 1'b0;
  logic        rst, start;
  logic [3:0]  addr, exp_ad;
  logic [4:0]  len;
  logic [15:0] rom, exp1, exp0;
  int          vectors = 0, miscompares = 0;
  always #5 clk = ~clk;
  rom16_reader_if b1();
  rom16_reader_if b0();
  assign b1.start = start;
  assign b1.addr  = addr;
  assign b1.len   = len;
  assign b1.di    = rom[b1.ad];
  assign b0.start = start;
  assign b0.addr  = addr;
  assign b0.len   = len;
  assign b0.di    = rom[b0.ad];
  rom16_reader #(.LSB_FIRST(1'b1)) dut1 (.i_clk(clk), .i_rst(rst), .bus(b1));
  rom16_reader #(.LSB_FIRST(1'b0)) dut0 (.i_clk(clk), .i_rst(rst), .bus(b0));
  function automatic logic [15:0] model(input logic [15:0] r, input int a, input int l, input bit lsb);
    logic [15:0] m = '0;
    for (int k = 0; k < l; k++)
      if (lsb) m[k] = r[(a + k) % 16];
      else     m[l - 1 - k] = r[(a + k) % 16];
    return m;
  endfunction
  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic idle_chk(input string tag);
    chk({tag, "_busy1"}, 16'(b1.busy), 16'd0);
    chk({tag, "_valid1"}, 16'(b1.valid), 16'd0);
    chk({tag, "_busy0"}, 16'(b0.busy), 16'd0);
    chk({tag, "_valid0"}, 16'(b0.valid), 16'd0);
    chk({tag, "_ad"}, 16'(b1.ad), 16'(exp_ad));
    chk({tag, "_data1"}, b1.data, exp1);
    chk({tag, "_data0"}, b0.data, exp0);
  endtask
  task automatic do_run(input int a, input int l, input int pulse);
    int L, lat;
    logic [15:0] m1, m0;
    L   = l > 16 ? 16 : l;
    lat = L + REGIN;
    addr = 4'(a); len = 5'(l); start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    if (L == 0) begin
      @(negedge clk);
      idle_chk("len0");
      return;
    end
    m1 = model(rom, a, L, 1'b1);
    m0 = model(rom, a, L, 1'b0);
    for (int e = 0; e <= lat; e++) begin
      start = (e + 1 == pulse);
      @(negedge clk);
      chk("busy", 16'(b1.busy), 16'(e < lat));
      chk("valid", 16'(b1.valid), 16'(e == lat));
      chk("valid0", 16'(b0.valid), 16'(e == lat));
      chk("ad", 16'(b1.ad), 16'((a + (e < L ? e : L)) % 16));
      chk("data1", b1.data, e == lat ? m1 : exp1);
      chk("data0", b0.data, e == lat ? m0 : exp0);
      if (e < lat) begin @(posedge clk); #1; end
    end
    start = 1'b0;
    exp1 = m1; exp0 = m0; exp_ad = 4'((a + L) % 16);
    @(negedge clk);
    idle_chk("post");
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end
  initial begin
    int a, l, p;
    rst = 1'b1; start = 1'b0; addr = '0; len = '0; rom = 16'hA5C3;
    exp1 = '0; exp0 = '0; exp_ad = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    idle_chk("reset");
    rst = 1'b0;
    do_run(0, 16, -1);
    chk("sweep_const", b1.data, 16'hA5C3);
    do_run(14, 4, -1);
    chk("wrap_const", b1.data, 16'h000E);
    do_run(0, 4, -1);
    chk("order_const", b0.data, 16'h000C);
    do_run(7, 0, -1);
    do_run(3, 8, 2);
    do_run(9, 20, -1);
    addr = 4'd5; len = 5'd16; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk); @(negedge clk);
    exp1 = '0; exp0 = '0; exp_ad = '0;
    idle_chk("midrst");
    rst = 1'b0;
    repeat (20) begin
      @(negedge clk);
      chk("midrst_novalid", 16'(b1.valid), 16'd0);
    end
    do_run(2, 16, -1);
    repeat (25) begin
      rom = 16'($urandom);
      a = int'($urandom_range(0, 15));
      l = int'($urandom_range(0, 20));
      p = (l >= 5 && $urandom_range(0, 1) == 1) ? int'($urandom_range(1, 4)) : -1;
      do_run(a, l, p);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
